// File: rtl/dc_frame_sched_pkg.sv
// Shared definitions for the DC-bias frame scheduler: FSM states, header
// field positions and the default frame geometry.
package dc_pkg;

   localparam int FRAME_WORDS_DEF = 62;
   localparam int N_CS_DEF        = 24;

   localparam int DISCARD_BIT = 31;
   localparam int MASK_LSB    = 0;
   localparam int MASK_W      = 24;
   localparam int DATA_W      = 24;
   localparam int CS_W        = 5;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      PAYLOAD  = 3'd1,
      SPI_WAIT = 3'd2,
      LDAC     = 3'd3,
      DONE     = 3'd4
   } state_e;

endpackage

// File: rtl/dc_frame_sched_gap_timer.sv
// Up-counter with enable, synchronous clear and a one-cycle expire pulse when
// the count reaches the terminal value presented on limit.
module dc_gap_timer #(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         clr,
   input  logic [W-1:0] limit,
   output logic         expire
);

   logic [W-1:0] count_r;

   assign expire = en && (count_r == (limit - W'(1)));

   // Count while enabled, hold otherwise, wrap to zero on expiry
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r <= W'(0);
      end else if (clr) begin
         count_r <= W'(0);
      end else if (en) begin
         count_r <= expire ? W'(0) : (count_r + W'(1));
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/dc_frame_sched.sv
// Frame scheduler: turns a header + payload word stream into per-chip SPI
// writes, then a single LDAC pulse; aborts frames stalled past the gap timeout.
module dc_frame_sched
   import dc_pkg::*;
#(
   parameter int FRAME_WORDS    = FRAME_WORDS_DEF,
   parameter int N_CS           = N_CS_DEF,
   parameter int LDAC_CYCLES    = 4,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [31:0]       i_word,
   input  logic              i_word_valid,
   output logic              o_word_ready,
   output logic              o_spi_start,
   output logic [CS_W-1:0]   o_spi_cs_idx,
   output logic [DATA_W-1:0] o_spi_data,
   input  logic              i_spi_done,
   output logic              o_ldac_n,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_err_timeout
);

   localparam int CNT_W   = $clog2(FRAME_WORDS + 1);
   localparam int TMR_MAX = (TIMEOUT_CYCLES > LDAC_CYCLES) ? TIMEOUT_CYCLES : LDAC_CYCLES;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_WORDS - 1);
   localparam logic [CNT_W-1:0] NCS_CNT  = CNT_W'(N_CS);

   state_e              state_r, state_nx_s;
   logic [CNT_W-1:0]    word_cnt_r, idx_s;
   logic [MASK_W-1:0]   mask_r;
   logic                discard_r, wrote_r, last_r;
   logic                accept_s, is_last_s, word_en_s, timeout_s;
   logic                tmr_en_s, tmr_clr_s, tmr_exp_s;
   logic [TMR_W-1:0]    tmr_limit_s;

   logic                ready_r, start_r, ldac_n_r, busy_r, frame_done_r, err_to_r;
   logic [CS_W-1:0]     cs_idx_r;
   logic [DATA_W-1:0]   data_r;

   // Header bits [30:24] are reserved and deliberately ignored
   logic unused_hdr_s;
   assign unused_hdr_s = ^i_word[30:24];

   // Word classification and next-state decode
   always_comb begin
      accept_s   = i_word_valid && ready_r;
      idx_s      = word_cnt_r - CNT_W'(1);
      is_last_s  = (word_cnt_r == LAST_IDX);
      word_en_s  = !discard_r && (word_cnt_r != CNT_W'(0)) && (word_cnt_r <= NCS_CNT)
                   && (|(mask_r & (MASK_W'(1) << idx_s)));
      timeout_s  = 1'b0;
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_nx_s = PAYLOAD;
            else          state_nx_s = IDLE;
         end
         PAYLOAD: begin
            if (accept_s) begin
               if (word_en_s)      state_nx_s = SPI_WAIT;
               else if (is_last_s) state_nx_s = wrote_r ? LDAC : DONE;
               else                state_nx_s = PAYLOAD;
            end else if (tmr_exp_s) begin
               state_nx_s = IDLE;
               timeout_s  = 1'b1;
            end else begin
               state_nx_s = PAYLOAD;
            end
         end
         SPI_WAIT: begin
            if (i_spi_done) state_nx_s = last_r ? LDAC : PAYLOAD;
            else            state_nx_s = SPI_WAIT;
         end
         LDAC: begin
            if (tmr_exp_s) state_nx_s = DONE;
            else           state_nx_s = LDAC;
         end
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // One timer serves both the inter-word gap and the LDAC pulse width;
   // it restarts on every accept and every state change
   always_comb begin
      tmr_en_s    = ((state_r == PAYLOAD) && !accept_s) || (state_r == LDAC);
      tmr_clr_s   = accept_s || (state_nx_s != state_r);
      tmr_limit_s = (state_r == LDAC) ? TMR_W'(LDAC_CYCLES) : TMR_W'(TIMEOUT_CYCLES);
   end

   dc_gap_timer #(
      .W (TMR_W)
   ) u_gap_timer (
      .clk    (i_clk),
      .rst    (i_rst),
      .en     (tmr_en_s),
      .clr    (tmr_clr_s),
      .limit  (tmr_limit_s),
      .expire (tmr_exp_s)
   );

   // State, frame bookkeeping and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r      <= IDLE;
         word_cnt_r   <= CNT_W'(0);
         mask_r       <= MASK_W'(0);
         discard_r    <= 1'b0;
         wrote_r      <= 1'b0;
         last_r       <= 1'b0;
         ready_r      <= 1'b0;
         start_r      <= 1'b0;
         cs_idx_r     <= CS_W'(0);
         data_r       <= DATA_W'(0);
         ldac_n_r     <= 1'b1;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         err_to_r     <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         ready_r      <= (state_nx_s == IDLE) || (state_nx_s == PAYLOAD);
         busy_r       <= (state_nx_s != IDLE);
         ldac_n_r     <= (state_nx_s != LDAC);
         frame_done_r <= (state_nx_s == DONE);
         err_to_r     <= timeout_s;
         start_r      <= 1'b0;

         if ((state_r == IDLE) && accept_s) begin
            mask_r     <= i_word[MASK_LSB +: MASK_W];
            discard_r  <= i_word[DISCARD_BIT];
            word_cnt_r <= CNT_W'(1);
            wrote_r    <= 1'b0;
            last_r     <= 1'b0;
         end else if ((state_r == PAYLOAD) && accept_s) begin
            word_cnt_r <= word_cnt_r + CNT_W'(1);
            if (word_en_s) begin
               start_r  <= 1'b1;
               cs_idx_r <= idx_s[CS_W-1:0];
               data_r   <= i_word[DATA_W-1:0];
               wrote_r  <= 1'b1;
               last_r   <= is_last_s;
            end
         end else if (state_r == DONE) begin
            wrote_r <= 1'b0;
         end
      end
   end

   assign o_word_ready  = ready_r;
   assign o_spi_start   = start_r;
   assign o_spi_cs_idx  = cs_idx_r;
   assign o_spi_data    = data_r;
   assign o_ldac_n      = ldac_n_r;
   assign o_busy        = busy_r;
   assign o_frame_done  = frame_done_r;
   assign o_err_timeout = err_to_r;

endmodule

// File: tb/tb_dc_frame_sched.sv
// Directed self-checking bench for dc_frame_sched with an SPI responder model.
module tb_dc_frame_sched;

   localparam int TO   = 200;
   localparam int NW   = 62;
   localparam int LDAC = 4;

   logic        clk = 1'b0;
   logic        i_rst = 1'b1;
   logic [31:0] i_word = 32'h0;
   logic        i_word_valid = 1'b0;
   logic        i_spi_done = 1'b0;
   logic        o_word_ready, o_spi_start, o_ldac_n, o_busy, o_frame_done, o_err_timeout;
   logic [4:0]  o_spi_cs_idx;
   logic [23:0] o_spi_data;

   dc_frame_sched #(
      .FRAME_WORDS    (NW),
      .N_CS           (24),
      .LDAC_CYCLES    (LDAC),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .i_word        (i_word),
      .i_word_valid  (i_word_valid),
      .o_word_ready  (o_word_ready),
      .o_spi_start   (o_spi_start),
      .o_spi_cs_idx  (o_spi_cs_idx),
      .o_spi_data    (o_spi_data),
      .i_spi_done    (i_spi_done),
      .o_ldac_n      (o_ldac_n),
      .o_busy        (o_busy),
      .o_frame_done  (o_frame_done),
      .o_err_timeout (o_err_timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Word k of the standard payload; upper byte is don't-care filler
   function automatic logic [31:0] payload(input int k);
      if (k == 1)      return 32'hAB345678;
      else if (k == 3) return 32'hAB030004;
      else             return {8'hAB, 8'(k - 1), 16'(k)};
   endfunction

   // SPI engine model: done pulse spi_delay cycles after each start
   int spi_delay = 2;
   int pend = 0;
   always @(negedge clk) begin
      i_spi_done = 1'b0;
      if (o_spi_start) pend = spi_delay;
      else if (pend > 0) begin
         pend--;
         if (pend == 0) i_spi_done = 1'b1;
      end
   end

   // Activity monitor, sampled mid-cycle
   int n_acc, n_start, n_ldac_low, n_ldac_pulse, n_done, n_err, lat_err, run, run_max, runs51;
   logic [4:0]  q_cs[$];
   logic [23:0] q_data[$];
   logic prev_acc = 1'b0, prev_ldac = 1'b1;
   always @(negedge clk) begin
      if (o_spi_start) begin
         n_start++;
         q_cs.push_back(o_spi_cs_idx);
         q_data.push_back(o_spi_data);
         if (!prev_acc) lat_err++;
      end
      prev_acc = i_word_valid && o_word_ready;
      if (prev_acc) n_acc++;
      if (!o_ldac_n) n_ldac_low++;
      if (!o_ldac_n && prev_ldac) n_ldac_pulse++;
      prev_ldac = o_ldac_n;
      if (o_frame_done) n_done++;
      if (o_err_timeout) n_err++;
      if (!o_word_ready) run++;
      else begin
         if (run == 51) runs51++;
         if (run > run_max) run_max = run;
         run = 0;
      end
   end

   task automatic clear_stats();
      n_acc = 0; n_start = 0; n_ldac_low = 0; n_ldac_pulse = 0; n_done = 0;
      n_err = 0; lat_err = 0; run = 0; run_max = 0; runs51 = 0;
      q_cs.delete(); q_data.delete();
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_word(input logic [31:0] w);
      int t;
      t = 0;
      i_word = w;
      i_word_valid = 1'b1;
      while (!o_word_ready && t < 3000) begin
         tick();
         t++;
      end
      if (t >= 3000) check_val("ready_wait_expired", 32'(t), 32'd0);
      tick();
   endtask

   task automatic send_frame(input logic [31:0] hdr, input int n);
      send_word(hdr);
      for (int k = 1; k <= n; k++) send_word(payload(k));
      i_word_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (o_busy && t < 5000) begin
         tick();
         t++;
      end
      if (t >= 5000) check_val("idle_wait_expired", 32'(t), 32'd0);
      repeat (2) tick();
   endtask

   initial begin
      clear_stats();
      // Reset values
      repeat (3) tick();
      check_val("rst_ready", {31'd0, o_word_ready}, 32'd0);
      check_val("rst_start", {31'd0, o_spi_start}, 32'd0);
      check_val("rst_cs", {27'd0, o_spi_cs_idx}, 32'd0);
      check_val("rst_data", {8'd0, o_spi_data}, 32'd0);
      check_val("rst_ldac_n", {31'd0, o_ldac_n}, 32'd1);
      check_val("rst_busy", {31'd0, o_busy}, 32'd0);
      check_val("rst_done_err", {30'd0, o_frame_done, o_err_timeout}, 32'd0);
      i_rst = 1'b0;
      tick();
      check_val("ready_after_rst", {31'd0, o_word_ready}, 32'd1);

      // Full mask, reserved header bits set
      clear_stats();
      send_frame(32'h7FFFFFFF, NW - 1);
      wait_idle();
      check_val("full_acc", 32'(n_acc), 32'd62);
      check_val("full_starts", 32'(n_start), 32'd24);
      check_val("full_first_cs", 32'(q_cs[0]), 32'd0);
      check_val("full_first_data", 32'(q_data[0]), 32'h345678);
      check_val("full_last_cs", 32'(q_cs[23]), 32'd23);
      check_val("full_last_data", 32'(q_data[23]), 32'h170018);
      begin
         int bad;
         bad = 0;
         for (int i = 0; i < 24; i++) if (q_cs[i] != 5'(i)) bad++;
         check_val("full_cs_order", 32'(bad), 32'd0);
      end
      check_val("full_latency", 32'(lat_err), 32'd0);
      check_val("full_ldac_low", 32'(n_ldac_low), 32'd4);
      check_val("full_ldac_pulses", 32'(n_ldac_pulse), 32'd1);
      check_val("full_frame_done", 32'(n_done), 32'd1);

      // Sparse mask: cs0 and cs2
      clear_stats();
      send_frame(32'h00000005, NW - 1);
      wait_idle();
      check_val("m5_starts", 32'(n_start), 32'd2);
      check_val("m5_cs0", 32'(q_cs[0]), 32'd0);
      check_val("m5_data0", 32'(q_data[0]), 32'h345678);
      check_val("m5_cs1", 32'(q_cs[1]), 32'd2);
      check_val("m5_data1", 32'(q_data[1]), 32'h030004);
      check_val("m5_ldac_pulses", 32'(n_ldac_pulse), 32'd1);
      check_val("m5_frame_done", 32'(n_done), 32'd1);

      // Discard frame
      clear_stats();
      send_frame(32'h80000000, NW - 1);
      wait_idle();
      check_val("disc_acc", 32'(n_acc), 32'd62);
      check_val("disc_starts", 32'(n_start), 32'd0);
      check_val("disc_ldac_low", 32'(n_ldac_low), 32'd0);
      check_val("disc_frame_done", 32'(n_done), 32'd1);

      // Empty mask without discard
      clear_stats();
      send_frame(32'h00000000, NW - 1);
      wait_idle();
      check_val("m0_starts", 32'(n_start), 32'd0);
      check_val("m0_ldac_low", 32'(n_ldac_low), 32'd0);
      check_val("m0_frame_done", 32'(n_done), 32'd1);

      // Stalled frame, then a normal one
      clear_stats();
      send_frame(32'h00FFFFFF, 10);
      repeat (TO + 10) tick();
      check_val("to_err_pulses", 32'(n_err), 32'd1);
      check_val("to_busy", {31'd0, o_busy}, 32'd0);
      check_val("to_starts", 32'(n_start), 32'd10);
      check_val("to_no_ldac", 32'(n_ldac_low), 32'd0);
      check_val("to_no_done", 32'(n_done), 32'd0);
      clear_stats();
      send_frame(32'h00000001, NW - 1);
      wait_idle();
      check_val("post_to_acc", 32'(n_acc), 32'd62);
      check_val("post_to_starts", 32'(n_start), 32'd1);
      check_val("post_to_ldac", 32'(n_ldac_pulse), 32'd1);
      check_val("post_to_done", 32'(n_done), 32'd1);
      check_val("post_to_err", 32'(n_err), 32'd0);

      // Slow SPI engine with valid held high throughout
      clear_stats();
      spi_delay = 50;
      send_frame(32'h00FFFFFF, NW - 1);
      wait_idle();
      check_val("slow_acc", 32'(n_acc), 32'd62);
      check_val("slow_starts", 32'(n_start), 32'd24);
      check_val("slow_runs51", 32'(runs51), 32'd24);
      check_val("slow_run_max", 32'(run_max), 32'd51);
      check_val("slow_done", 32'(n_done), 32'd1);

      // Reset while waiting on SPI; the late done must be ignored
      clear_stats();
      spi_delay = 20;
      i_word = 32'h00000001;
      i_word_valid = 1'b1;
      tick();
      i_word = payload(1);
      tick();
      i_word_valid = 1'b0;
      check_val("sw_start", {31'd0, o_spi_start}, 32'd1);
      repeat (2) tick();
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check_val("sw_rst_ldac_n", {31'd0, o_ldac_n}, 32'd1);
      check_val("sw_rst_busy", {31'd0, o_busy}, 32'd0);
      check_val("sw_rst_start", {31'd0, o_spi_start}, 32'd0);
      repeat (30) tick();
      check_val("sw_late_busy", {31'd0, o_busy}, 32'd0);
      check_val("sw_late_ready", {31'd0, o_word_ready}, 32'd1);
      check_val("sw_late_starts", 32'(n_start), 32'd1);
      check_val("sw_late_ldac", 32'(n_ldac_low), 32'd0);

      // Reset during the LDAC pulse
      clear_stats();
      spi_delay = 2;
      send_frame(32'h00000001, NW - 1);
      begin
         int t;
         t = 0;
         while (o_ldac_n && t < 200) begin
            tick();
            t++;
         end
         check_val("ld_reached", {31'd0, o_ldac_n}, 32'd0);
      end
      i_rst = 1'b1;
      tick();
      i_rst = 1'b0;
      check_val("ld_rst_ldac_n", {31'd0, o_ldac_n}, 32'd1);
      check_val("ld_rst_busy", {31'd0, o_busy}, 32'd0);
      check_val("ld_rst_start", {31'd0, o_spi_start}, 32'd0);
      repeat (5) tick();
      check_val("ld_no_done", 32'(n_done), 32'd0);
      clear_stats();
      send_frame(32'h80000000, NW - 1);
      wait_idle();
      check_val("ld_recover_done", 32'(n_done), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
